// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one async-read single-port RAM between fetch and data ports.
// Latency: loads and fetches return one cycle after grant; partial stores complete two cycles after grant.
// Backpressure: a requester holds req until gnt; nothing is granted during the read-modify-write cycle.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [STRB_W-1:0]     d_wstrb,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_spo
);

  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;
  typedef enum logic {PRIO_D = 1'b0, PRIO_I = 1'b1} prio_t;

  state_t                r_state;
  prio_t                 r_prio;
  logic                  r_i_rvalid;
  logic                  r_d_rvalid;
  logic [DATA_WIDTH-1:0] r_i_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic [ADDR_WIDTH-1:0] r_rmw_addr;
  logic [DATA_WIDTH-1:0] r_rmw_data;

  logic                  w_arb_en;
  logic                  w_i_gnt;
  logic                  w_d_gnt;
  logic                  w_strb_full;
  logic                  w_strb_zero;
  logic                  w_partial;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_merged;

  // Grants depend only on req, state and prio; the RMW write cycle and reset block both ports.
  always_comb begin
    w_arb_en    = (r_state == IDLE) && !reset;
    w_i_gnt     = w_arb_en && i_req && (!d_req || (r_prio == PRIO_I));
    w_d_gnt     = w_arb_en && d_req && (!i_req || (r_prio == PRIO_D));
    w_strb_full = &d_wstrb;
    w_strb_zero = ~|d_wstrb;
    w_partial   = !w_strb_full && !w_strb_zero;
  end

  // Expand byte strobes to a bit mask and merge new bytes over the current RAM word.
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < STRB_W; k++) begin
      w_mask[8*k +: 8] = {8{d_wstrb[k]}};
    end
    w_merged = (ram_spo & ~w_mask) | (d_wdata & w_mask);
  end

  // RAM port steering: saved address/merged word in RMW_WR, otherwise the granted (or fetch) address.
  always_comb begin
    if (r_state == RMW_WR) begin
      ram_a = r_rmw_addr;
      ram_d = r_rmw_data;
    end else begin
      ram_a = w_d_gnt ? d_addr : i_addr;
      ram_d = d_wdata;
    end
    ram_we = !reset && ((r_state == RMW_WR) || (w_d_gnt && d_we && w_strb_full));
  end

  // Arbiter FSM: priority rotation, read data capture, response pulses and RMW sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_prio     <= PRIO_D;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
      r_rmw_addr <= '0;
      r_rmw_data <= '0;
    end else begin
      r_i_rvalid <= w_i_gnt;
      r_d_rvalid <= 1'b0;
      if (w_i_gnt) begin
        r_i_rdata <= ram_spo;
      end
      case (r_state)
        IDLE: begin
          if (w_i_gnt) begin
            r_prio <= PRIO_D;
          end
          if (w_d_gnt) begin
            r_prio <= PRIO_I;
            if (!d_we) begin
              r_d_rdata  <= ram_spo;
              r_d_rvalid <= 1'b1;
            end else if (w_partial) begin
              r_rmw_addr <= d_addr;
              r_rmw_data <= w_merged;
              r_state    <= RMW_WR;
            end else begin
              r_d_rvalid <= 1'b1;
            end
          end
        end
        RMW_WR: begin
          r_d_rvalid <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i_gnt    = w_i_gnt;
  assign d_gnt    = w_d_gnt;
  assign i_rvalid = r_i_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rvalid = r_d_rvalid;
  assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural async-read RAM attached.
// Inputs change at the falling edge; outputs are sampled 1 time unit later.
// Registered outputs seen after a falling edge belong to the cycle after the grant.
module tb_ram_port_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk;
  logic          reset;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic          d_we;
  logic [SW-1:0] d_wstrb;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] ram_a;
  logic          ram_we;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_spo;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_we;
  logic [AW-1:0] pre_a;
  logic [DW-1:0] pre_d;

  int total;
  int bad;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_a(ram_a), .ram_we(ram_we), .ram_d(ram_d), .ram_spo(ram_spo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: async read, sync write; the bench preloads through a side port.
  assign ram_spo = mem[ram_a];
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
    else if (pre_we) mem[pre_a] <= pre_d;
  end

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    next_cycle();
    pre_we = 1'b1; pre_a = a; pre_d = d;
    next_cycle();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hF; d_addr = 15'h20; i_addr = 15'h4;
    #1;
    total++; if (i_gnt !== 1'b0) begin bad++; $display("FAIL reset_i_gnt got=%b want=0", i_gnt); end
    total++; if (d_gnt !== 1'b0) begin bad++; $display("FAIL reset_d_gnt got=%b want=0", d_gnt); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we got=%b want=0", ram_we); end
    next_cycle(); #1;
    total++; if (i_rvalid !== 1'b0) begin bad++; $display("FAIL reset_i_rvalid got=%b want=0", i_rvalid); end
    total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL reset_d_rvalid got=%b want=0", d_rvalid); end
    total++; if (i_rdata !== 32'h0) begin bad++; $display("FAIL reset_i_rdata got=%h want=0", i_rdata); end
    total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL reset_d_rdata got=%h want=0", d_rdata); end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic test_fetch();
    next_cycle();
    reset = 1'b0; i_addr = 15'h7; d_wdata = 32'h0BADF00D;
    #1;
    total++; if (ram_a !== 15'h7) begin bad++; $display("FAIL idle_ram_a got=%h want=0007", ram_a); end
    total++; if (ram_d !== 32'h0BADF00D) begin bad++; $display("FAIL idle_ram_d got=%h want=0badf00d", ram_d); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL idle_ram_we got=%b want=0", ram_we); end
    next_cycle();
    i_req = 1'b1; i_addr = 15'h4;
    #1;
    total++; if (i_gnt !== 1'b1) begin bad++; $display("FAIL fetch_i_gnt got=%b want=1", i_gnt); end
    total++; if (ram_a !== 15'h4) begin bad++; $display("FAIL fetch_ram_a got=%h want=0004", ram_a); end
    next_cycle();
    i_req = 1'b0;
    #1;
    total++; if (i_rvalid !== 1'b1) begin bad++; $display("FAIL fetch_i_rvalid got=%b want=1", i_rvalid); end
    total++; if (i_rdata !== 32'h02800413) begin bad++; $display("FAIL fetch_i_rdata got=%h want=02800413", i_rdata); end
    next_cycle(); #1;
    total++; if (i_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_rvalid_pulse got=%b want=0", i_rvalid); end
  endtask

  task automatic test_round_robin();
    logic exp_d;
    next_cycle();
    reset = 1'b1; i_req = 1'b1; i_addr = 15'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 15'h10;
    next_cycle();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) next_cycle();
      if (k == 4) begin i_req = 1'b0; d_req = 1'b0; end
      #1;
      if (k < 4) begin
        exp_d = (k % 2 == 0);
        total++; if (d_gnt !== exp_d) begin bad++; $display("FAIL rr_d_gnt cyc=%0d got=%b want=%b", k, d_gnt, exp_d); end
        total++; if (i_gnt !== !exp_d) begin bad++; $display("FAIL rr_i_gnt cyc=%0d got=%b want=%b", k, i_gnt, !exp_d); end
      end
      if (k > 0) begin
        exp_d = ((k - 1) % 2 == 0);
        total++; if (d_rvalid !== exp_d) begin bad++; $display("FAIL rr_d_rvalid cyc=%0d got=%b want=%b", k, d_rvalid, exp_d); end
        total++; if (i_rvalid !== !exp_d) begin bad++; $display("FAIL rr_i_rvalid cyc=%0d got=%b want=%b", k, i_rvalid, !exp_d); end
        if (exp_d) begin
          total++; if (d_rdata !== 32'hCAFE0010) begin bad++; $display("FAIL rr_d_rdata cyc=%0d got=%h want=cafe0010", k, d_rdata); end
        end else begin
          total++; if (i_rdata !== 32'h12345678) begin bad++; $display("FAIL rr_i_rdata cyc=%0d got=%h want=12345678", k, i_rdata); end
        end
      end
    end
  endtask

  task automatic test_full_store();
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'hF; d_addr = 15'h20; d_wdata = 32'hDEADBEEF;
    #1;
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL st_d_gnt got=%b want=1", d_gnt); end
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL st_ram_we got=%b want=1", ram_we); end
    total++; if (ram_d !== 32'hDEADBEEF) begin bad++; $display("FAIL st_ram_d got=%h want=deadbeef", ram_d); end
    total++; if (ram_a !== 15'h20) begin bad++; $display("FAIL st_ram_a got=%h want=0020", ram_a); end
    next_cycle();
    d_we = 1'b0;
    #1;
    total++; if (d_rvalid !== 1'b1) begin bad++; $display("FAIL st_d_rvalid got=%b want=1", d_rvalid); end
    total++; if (d_rdata !== 32'hCAFE0010) begin bad++; $display("FAIL st_d_rdata_hold got=%h want=cafe0010", d_rdata); end
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL st_ld_gnt got=%b want=1", d_gnt); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL st_ld_ram_we got=%b want=0", ram_we); end
    next_cycle();
    d_req = 1'b0;
    #1;
    total++; if (d_rvalid !== 1'b1) begin bad++; $display("FAIL st_ld_rvalid got=%b want=1", d_rvalid); end
    total++; if (d_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL st_ld_rdata got=%h want=deadbeef", d_rdata); end
  endtask

  task automatic test_partial_store();
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'b0010; d_addr = 15'h21; d_wdata = 32'h0000AA00; i_req = 1'b0;
    #1;
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL rmw_d_gnt got=%b want=1", d_gnt); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rmw_rd_ram_we got=%b want=0", ram_we); end
    total++; if (ram_a !== 15'h21) begin bad++; $display("FAIL rmw_rd_ram_a got=%h want=0021", ram_a); end
    next_cycle();
    d_req = 1'b0; i_req = 1'b1; i_addr = 15'h4;
    #1;
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL rmw_wr_ram_we got=%b want=1", ram_we); end
    total++; if (ram_d !== 32'h1122AA44) begin bad++; $display("FAIL rmw_wr_ram_d got=%h want=1122aa44", ram_d); end
    total++; if (ram_a !== 15'h21) begin bad++; $display("FAIL rmw_wr_ram_a got=%h want=0021", ram_a); end
    total++; if (i_gnt !== 1'b0) begin bad++; $display("FAIL rmw_wr_i_gnt got=%b want=0", i_gnt); end
    total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL rmw_wr_d_rvalid got=%b want=0", d_rvalid); end
    next_cycle(); #1;
    total++; if (d_rvalid !== 1'b1) begin bad++; $display("FAIL rmw_d_rvalid got=%b want=1", d_rvalid); end
    total++; if (i_gnt !== 1'b1) begin bad++; $display("FAIL rmw_after_i_gnt got=%b want=1", i_gnt); end
    total++; if (mem[15'h21] !== 32'h1122AA44) begin bad++; $display("FAIL rmw_mem got=%h want=1122aa44", mem[15'h21]); end
    next_cycle();
    i_req = 1'b0;
    #1;
    total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL rmw_d_rvalid_pulse got=%b want=0", d_rvalid); end
    total++; if (i_rdata !== 32'h02800413) begin bad++; $display("FAIL rmw_i_rdata got=%h want=02800413", i_rdata); end
  endtask

  task automatic test_rmw_reset();
    preload(15'h21, 32'h11223344);
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'b0010; d_addr = 15'h21; d_wdata = 32'h0000AA00; i_req = 1'b0;
    #1;
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL rst_rmw_d_gnt got=%b want=1", d_gnt); end
    next_cycle();
    reset = 1'b1; i_req = 1'b1; i_addr = 15'h8; d_we = 1'b0; d_addr = 15'h10;
    #1;
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_rmw_ram_we got=%b want=0", ram_we); end
    total++; if (d_gnt !== 1'b0) begin bad++; $display("FAIL rst_rmw_d_gnt_rst got=%b want=0", d_gnt); end
    next_cycle();
    reset = 1'b0;
    #1;
    total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rmw_d_rvalid got=%b want=0", d_rvalid); end
    total++; if (mem[15'h21] !== 32'h11223344) begin bad++; $display("FAIL rst_rmw_mem got=%h want=11223344", mem[15'h21]); end
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL rst_rmw_first_d_gnt got=%b want=1", d_gnt); end
    total++; if (i_gnt !== 1'b0) begin bad++; $display("FAIL rst_rmw_first_i_gnt got=%b want=0", i_gnt); end
    next_cycle();
    i_req = 1'b0; d_req = 1'b0;
    #1;
    total++; if (d_rdata !== 32'hCAFE0010) begin bad++; $display("FAIL rst_rmw_d_rdata got=%h want=cafe0010", d_rdata); end
  endtask

  task automatic test_zero_strobe();
    preload(15'h30, 32'h55667788);
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_wstrb = 4'b0000; d_addr = 15'h30; d_wdata = 32'hFFFFFFFF;
    #1;
    total++; if (d_gnt !== 1'b1) begin bad++; $display("FAIL zs_d_gnt got=%b want=1", d_gnt); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL zs_ram_we got=%b want=0", ram_we); end
    next_cycle();
    d_req = 1'b0;
    #1;
    total++; if (d_rvalid !== 1'b1) begin bad++; $display("FAIL zs_d_rvalid got=%b want=1", d_rvalid); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL zs_ram_we_after got=%b want=0", ram_we); end
    next_cycle(); #1;
    total++; if (mem[15'h30] !== 32'h55667788) begin bad++; $display("FAIL zs_mem got=%h want=55667788", mem[15'h30]); end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_wstrb = '0; d_addr = '0; d_wdata = '0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0;
    test_reset();
    preload(15'h4, 32'h02800413);
    preload(15'h8, 32'h12345678);
    preload(15'h10, 32'hCAFE0010);
    preload(15'h21, 32'h11223344);
    test_fetch();
    test_round_robin();
    test_full_store();
    test_partial_store();
    test_rmw_reset();
    test_zero_strobe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port RAM (asynchronous read, synchronous word write, full-word `we` only) between the instruction-fetch port and the data-access port.
- Round-robin arbitration; one access per cycle.
- Turns partial-byte stores into a two-cycle read-modify-write.
- Sits between the core's fetch/LSU front ends and the instruction/data RAM in the single-cycle SoC.

Parameters:
- ADDR_WIDTH, 15, word address width; must equal the RAM address width.
- DATA_WIDTH, 32, word width; must be a multiple of 8. Derived STRB_W = DATA_WIDTH/8.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch read request; held with i_addr until i_gnt.
- i_addr  in  ADDR_WIDTH  fetch word address.
- i_gnt  out  1  fetch request accepted this cycle (combinational).
- i_rvalid  out  1  i_rdata valid; one-cycle pulse.
- i_rdata  out  DATA_WIDTH  registered fetch read data.
- d_req  in  1  data request; held with all d_* inputs until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_wstrb  in  STRB_W  byte enables for a store; bit k covers bits [8k+7:8k].
- d_addr  in  ADDR_WIDTH  data word address.
- d_wdata  in  DATA_WIDTH  store data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  load data valid, or store complete; one-cycle pulse.
- d_rdata  out  DATA_WIDTH  registered load data; holds its previous value after a store.
- ram_a  out  ADDR_WIDTH  RAM address.
- ram_we  out  1  RAM write enable.
- ram_d  out  DATA_WIDTH  RAM write data.
- ram_spo  in  DATA_WIDTH  RAM asynchronous read data.

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high.
- Reset values: state=IDLE, prio=DATA, i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0.
  - While reset is high: i_gnt=0, d_gnt=0, ram_we=0.
- States:
  - IDLE: arbitrate and serve.
  - RMW_WR: write the merged word.
- Arbitration in IDLE:
  - Only one requester asserted → it is granted.
  - Both asserted → the requester named by prio is granted.
  - After any grant, prio points to the other port.
  - No request → prio is unchanged and ram_we=0.
- Combinational-path rule: a grant is a combinational function of req, state and prio. Requesters must not derive req from gnt.
- RAM port in the grant cycle:
  - ram_a = the granted address.
  - With no grant, ram_a = i_addr and ram_d = d_wdata.
- Load or fetch granted in cycle N:
  - ram_spo is captured into the port's rdata register at the end of cycle N.
  - rvalid=1 in cycle N+1 only.
  - A new request may be granted in cycle N+1, so throughput is 1 access per cycle.
- Full store (d_wstrb all ones), granted in cycle N:
  - ram_we=1 and ram_d=d_wdata in cycle N.
  - d_rvalid=1 in cycle N+1.
  - State stays IDLE.
- Partial store (d_wstrb neither all ones nor zero), granted in cycle N:
  - Cycle N: ram_we=0, ram_a=d_addr. Register merged = (ram_spo & ~mask) | (d_wdata & mask), where mask expands d_wstrb to bytes. Also register the address. Go to RMW_WR.
  - Cycle N+1 (RMW_WR): ram_a=saved address, ram_d=merged, ram_we=1. No grant to either port; prio is unchanged. Return to IDLE.
  - d_rvalid=1 in cycle N+2.
- Zero-strobe store: granted normally. ram_we stays 0 and d_rvalid=1 in cycle N+1.
- Request withdrawn before grant: legal; no side effects.
- Reset asserted in RMW_WR: the pending write is abandoned (ram_we=0), no d_rvalid is issued, and state goes to IDLE.
- Address width: no wrap or range check is performed; the address passes through unchanged.
- At most one rvalid is asserted per cycle, because grants are exclusive.

Test Plan:
1. Reset, then i_req=1, i_addr=0x0004 with RAM[4]=0x02800413 → i_gnt=1 that cycle; next cycle i_rvalid=1, i_rdata=0x02800413.
2. i_req and d_req (load, addr 0x10) held continuously from reset release → grants alternate D,I,D,I. Each rvalid follows its grant by one cycle. No cycle has both gnts high.
3. Full store d_addr=0x20, d_wdata=0xDEADBEEF, d_wstrb=4'b1111 → ram_we=1 in the grant cycle, d_rvalid next cycle. A subsequent load of 0x20 returns 0xDEADBEEF.
4. RAM[0x21]=0x11223344; store d_wstrb=4'b0010, d_wdata=0x0000AA00 → ram_we=0 in the grant cycle. Next cycle ram_we=1, ram_d=0x1122AA44, and i_gnt=0 even with i_req=1. d_rvalid one cycle later.
5. Partial store as in 4, with reset pulsed during RMW_WR → RAM[0x21] stays 0x11223344, no d_rvalid, first grant after reset goes to data when both ports request.
6. d_req=1, d_we=1, d_wstrb=0 → d_gnt=1, ram_we never asserted, d_rvalid next cycle, RAM unchanged.
